// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA timing generator.
//   phase_t    - per-axis phase (ACTIVE -> FRONT -> SYNC -> BACK)
//   cnt_t      - 10-bit axis counter type
//   DEF_*      - default 640x480@60 timing (25.175 MHz pixel clock)
//   next_count - wrap-around increment shared by the axis and the top-level
//                output decode so that both agree on the next count.
package vga_pkg;

    localparam int CNT_W         = 10;
    localparam int CNT_MAX_TOTAL = 1 << CNT_W;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam bit DEF_HS_POL = 1'b0;
    localparam bit DEF_VS_POL = 1'b0;

    // Count value after one clock: holds without step, wraps after last.
    function automatic cnt_t next_count(input cnt_t cnt, input cnt_t last, input logic step);
        if (!step) begin
            return cnt;
        end else if (cnt == last) begin
            return '0;
        end else begin
            return cnt + cnt_t'(1);
        end
    endfunction

endpackage

// File: rtl/vga_axis.sv
// vga_axis: one timing axis (horizontal or vertical).
//   Parameters: ACT/FP/SYNC/BP phase lengths in counts, POL sync asserted level.
//   clk_i  in   clock
//   rst_i  in   asynchronous active-high reset
//   clr    in   force count to 0 and phase to ACTIVE on the next clock
//   step   in   advance the count by one this clock
//   cnt    out  current count
//   active out  count is inside the active region
//   sync   out  sync output at its asserted level during the SYNC phase
//   last   out  count is the final value of the axis period
// All outputs are registered and decoded from the next-state values, so they
// always describe the count currently held in cnt.
module vga_axis #(
    parameter int ACT  = vga_pkg::DEF_H_ACT,
    parameter int FP   = vga_pkg::DEF_H_FP,
    parameter int SYNC = vga_pkg::DEF_H_SYNC,
    parameter int BP   = vga_pkg::DEF_H_BP,
    parameter bit POL  = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr,
    input  logic          step,
    output vga_pkg::cnt_t cnt,
    output logic          active,
    output logic          sync,
    output logic          last
);

    localparam int TOTAL = ACT + FP + SYNC + BP;

    // The phase FSM needs every phase to last at least one count, and the
    // period has to fit the 10-bit counter.
    generate
        if (TOTAL > vga_pkg::CNT_MAX_TOTAL || ACT < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
            $error("vga_axis: period must fit a 10-bit counter and each phase must be non-empty");
        end
    endgenerate

    localparam vga_pkg::cnt_t FRONT_AT = vga_pkg::cnt_t'(ACT);
    localparam vga_pkg::cnt_t SYNC_AT  = vga_pkg::cnt_t'(ACT + FP);
    localparam vga_pkg::cnt_t BACK_AT  = vga_pkg::cnt_t'(ACT + FP + SYNC);
    localparam vga_pkg::cnt_t LAST_AT  = vga_pkg::cnt_t'(TOTAL - 1);

    vga_pkg::phase_t phase_reg, phase_next;
    vga_pkg::cnt_t   cnt_reg, cnt_next;
    logic            active_reg, sync_reg, last_reg;
    logic            active_next, sync_next, last_next;

    always_comb begin
        cnt_next   = vga_pkg::next_count(cnt_reg, LAST_AT, step);
        phase_next = phase_reg;
        if (clr) begin
            cnt_next   = '0;
            phase_next = vga_pkg::ACTIVE;
        end else if (step) begin
            case (phase_reg)
                vga_pkg::ACTIVE: if (cnt_next == FRONT_AT) phase_next = vga_pkg::FRONT;
                vga_pkg::FRONT:  if (cnt_next == SYNC_AT)  phase_next = vga_pkg::SYNC;
                vga_pkg::SYNC:   if (cnt_next == BACK_AT)  phase_next = vga_pkg::BACK;
                vga_pkg::BACK:   if (cnt_next == '0)       phase_next = vga_pkg::ACTIVE;
                default:         phase_next = vga_pkg::ACTIVE;
            endcase
        end
        active_next = (phase_next == vga_pkg::ACTIVE);
        sync_next   = (phase_next == vga_pkg::SYNC) ? POL : ~POL;
        last_next   = (cnt_next == LAST_AT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg    <= '0;
            phase_reg  <= vga_pkg::ACTIVE;
            active_reg <= 1'b0;
            sync_reg   <= ~POL;
            last_reg   <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            phase_reg  <= phase_next;
            active_reg <= active_next;
            sync_reg   <= sync_next;
            last_reg   <= last_next;
        end
    end

    assign cnt    = cnt_reg;
    assign active = active_reg;
    assign sync   = sync_reg;
    assign last   = last_reg;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator (default 640x480@60).
//   clk_i     in   pixel clock
//   rst_i     in   asynchronous active-high reset
//   en        in   run enable; low holds both counters at 0
//   hsync     out  horizontal sync (HS_POL = asserted level)
//   vsync     out  vertical sync (VS_POL = asserted level)
//   h_active  out  current column is active
//   v_active  out  current line is active
//   eol       out  one-clock pulse at column H_ACT of every line
//   eof       out  one-clock pulse at the last pixel of the frame
//   x, y      out  active column/line, 0 outside the active region
// Every output is a register loaded from next-state values, so each one
// matches the counters held in the same cycle.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit HS_POL = DEF_HS_POL,
    parameter bit VS_POL = DEF_VS_POL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             h_active,
    output logic             v_active,
    output logic             eol,
    output logic             eof,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y
);

    localparam int   H_TOTAL  = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL  = V_ACT + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT_C  = cnt_t'(H_ACT);
    localparam cnt_t V_ACT_C  = cnt_t'(V_ACT);

    logic clr;
    cnt_t h_cnt, v_cnt;
    logic h_act, h_sync, h_last;
    logic v_act, v_sync, v_last;

    assign clr = ~en;

    vga_axis #(
        .ACT  (H_ACT),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .POL  (HS_POL)
    ) u_h_axis (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (clr),
        .step   (1'b1),
        .cnt    (h_cnt),
        .active (h_act),
        .sync   (h_sync),
        .last   (h_last)
    );

    // The line counter steps on the final column, so it wraps together with
    // the column counter.
    vga_axis #(
        .ACT  (V_ACT),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .POL  (VS_POL)
    ) u_v_axis (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (clr),
        .step   (h_last),
        .cnt    (v_cnt),
        .active (v_act),
        .sync   (v_sync),
        .last   (v_last)
    );

    // Next counter values, used to pre-decode the pulse and position outputs.
    cnt_t h_next, v_next;
    logic eol_reg, eof_reg;
    cnt_t x_reg, y_reg;

    always_comb begin
        h_next = '0;
        v_next = '0;
        if (en) begin
            h_next = next_count(h_cnt, H_LAST, 1'b1);
            v_next = next_count(v_cnt, V_LAST, h_last);
        end
    end

    // While h_next is below H_LAST the line count does not move, so v_last
    // already describes the line of the next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eol_reg <= 1'b0;
            eof_reg <= 1'b0;
            x_reg   <= '0;
            y_reg   <= '0;
        end else begin
            eol_reg <= (h_next == H_ACT_C);
            eof_reg <= (h_next == H_LAST) && v_last;
            x_reg   <= (h_next < H_ACT_C) ? h_next : '0;
            y_reg   <= (v_next < V_ACT_C) ? v_next : '0;
        end
    end

    assign hsync    = h_sync;
    assign vsync    = v_sync;
    assign h_active = h_act;
    assign v_active = v_act;
    assign eol      = eol_reg;
    assign eof      = eof_reg;
    assign x        = x_reg;
    assign y        = y_reg;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: two instances of vga_timing -- dut0 with the default
// 640x480 timing and dut1 with a 320-column line, active-high hsync and a
// short 13-line frame so whole frames fit in a short run. A counter-based
// raster model tracks each instance and is compared every cycle; a table of
// line-timing points and a few hand-written sequences cover the corner cases.
module tb_vga_timing;

    typedef struct {
        int h_act, h_fp, h_sync, h_bp;
        int v_act, v_fp, v_sync, v_bp;
        bit hs_pol, vs_pol;
    } tim_t;

    typedef struct packed {
        logic       hs, vs, ha, va, eol, eof;
        logic [9:0] x, y;
    } outs_t;

    typedef struct {
        int n;
        bit ha, hs, eol;
        int x, y;
    } vec_t;

    tim_t tim0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    tim_t tim1 = '{320, 8, 48, 24, 6, 2, 2, 3, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, en0 = 1'b1, rst1 = 1'b1, en1 = 1'b1;
    logic hsync0, vsync0, h_active0, v_active0, eol0, eof0;
    logic hsync1, vsync1, h_active1, v_active1, eol1, eof1;
    logic [9:0] x0, y0, x1, y1;

    vga_timing dut0 (
        .clk_i(clk), .rst_i(rst0), .en(en0),
        .hsync(hsync0), .vsync(vsync0), .h_active(h_active0), .v_active(v_active0),
        .eol(eol0), .eof(eof0), .x(x0), .y(y0)
    );

    vga_timing #(
        .H_ACT(320), .H_FP(8), .H_SYNC(48), .H_BP(24),
        .V_ACT(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut1 (
        .clk_i(clk), .rst_i(rst1), .en(en1),
        .hsync(hsync1), .vsync(vsync1), .h_active(h_active1), .v_active(v_active1),
        .eol(eol1), .eof(eof1), .x(x1), .y(y1)
    );

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    // ---------------- reference raster model ----------------
    function automatic int htot(input tim_t t);
        return t.h_act + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int vtot(input tim_t t);
        return t.v_act + t.v_fp + t.v_sync + t.v_bp;
    endfunction

    // live=0 means reset is (or was last) in force with no clock since.
    function automatic outs_t model(input int h, input int v, input bit live, input tim_t t);
        outs_t o;
        o = '0;
        o.hs = ~t.hs_pol;
        o.vs = ~t.vs_pol;
        if (live) begin
            o.ha  = (h < t.h_act);
            o.va  = (v < t.v_act);
            if (h >= t.h_act + t.h_fp && h < t.h_act + t.h_fp + t.h_sync) o.hs = t.hs_pol;
            if (v >= t.v_act + t.v_fp && v < t.v_act + t.v_fp + t.v_sync) o.vs = t.vs_pol;
            o.eol = (h == t.h_act);
            o.eof = (h == htot(t) - 1) && (v == vtot(t) - 1);
            if (o.ha) o.x = 10'(h);
            if (o.va) o.y = 10'(v);
        end
        return o;
    endfunction

    int h0 = 0, v0 = 0, h1 = 0, v1 = 0;
    bit live0 = 1'b0, live1 = 1'b0;

    always @(posedge clk or posedge rst0) begin
        if (rst0) begin
            h0 <= 0; v0 <= 0; live0 <= 1'b0;
        end else begin
            live0 <= 1'b1;
            if (!en0) begin
                h0 <= 0; v0 <= 0;
            end else begin
                h0 <= (h0 + 1) % htot(tim0);
                if (h0 == htot(tim0) - 1) v0 <= (v0 + 1) % vtot(tim0);
            end
        end
    end

    always @(posedge clk or posedge rst1) begin
        if (rst1) begin
            h1 <= 0; v1 <= 0; live1 <= 1'b0;
        end else begin
            live1 <= 1'b1;
            if (!en1) begin
                h1 <= 0; v1 <= 0;
            end else begin
                h1 <= (h1 + 1) % htot(tim1);
                if (h1 == htot(tim1) - 1) v1 <= (v1 + 1) % vtot(tim1);
            end
        end
    end

    task automatic cmp_model(input string name, input outs_t g, input outs_t e);
        tests++;
        if (g != e) begin
            fails++;
            $display("FAIL %s t=%0t got hs%0b vs%0b ha%0b va%0b eol%0b eof%0b x%0d y%0d, expected hs%0b vs%0b ha%0b va%0b eol%0b eof%0b x%0d y%0d",
                     name, $time, g.hs, g.vs, g.ha, g.va, g.eol, g.eof, g.x, g.y,
                     e.hs, e.vs, e.ha, e.va, e.eol, e.eof, e.x, e.y);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp_model("model_dut0", '{hsync0, vsync0, h_active0, v_active0, eol0, eof0, x0, y0},
                      model(h0, v0, live0, tim0));
            cmp_model("model_dut1", '{hsync1, vsync1, h_active1, v_active1, eol1, eof1, x1, y1},
                      model(h1, v1, live1, tim1));
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[12];
    int n, k, c_ha, c_hsl, c_eol, eol_at, hsl_at, c_va, c_vsl, c_hsh, off, rhold;

    initial begin
        // n = clocks since reset release; column = n mod 800, line = n / 800
        tbl[0]  = '{1,    1'b1, 1'b1, 1'b0, 1,   0};
        tbl[1]  = '{639,  1'b1, 1'b1, 1'b0, 639, 0};
        tbl[2]  = '{640,  1'b0, 1'b1, 1'b1, 0,   0};
        tbl[3]  = '{641,  1'b0, 1'b1, 1'b0, 0,   0};
        tbl[4]  = '{655,  1'b0, 1'b1, 1'b0, 0,   0};
        tbl[5]  = '{656,  1'b0, 1'b0, 1'b0, 0,   0};
        tbl[6]  = '{751,  1'b0, 1'b0, 1'b0, 0,   0};
        tbl[7]  = '{752,  1'b0, 1'b1, 1'b0, 0,   0};
        tbl[8]  = '{799,  1'b0, 1'b1, 1'b0, 0,   0};
        tbl[9]  = '{800,  1'b1, 1'b1, 1'b0, 0,   1};
        tbl[10] = '{801,  1'b1, 1'b1, 1'b0, 1,   1};
        tbl[11] = '{1440, 1'b0, 1'b1, 1'b1, 0,   1};

        repeat (3) @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        chk("reset_hsync", hsync0, 1);
        chk("reset_vsync", vsync0, 1);
        chk("reset_h_active", h_active0, 0);
        chk("reset_v_active", v_active0, 0);
        chk("reset_xy", int'(x0) + int'(y0), 0);
        chk("reset_eol_eof", int'(eol0) + int'(eof0), 0);
        $display("[TB] reset state checked");

        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0; n = 0;

        // line timing table on the default-timing instance
        for (int i = 0; i < 12; i++) begin
            while (n < tbl[i].n) begin @(posedge clk); n++; end
            @(negedge clk);
            chk($sformatf("vec%0d_h_active", i), h_active0, tbl[i].ha);
            chk($sformatf("vec%0d_hsync", i), hsync0, tbl[i].hs);
            chk($sformatf("vec%0d_eol", i), eol0, tbl[i].eol);
            chk($sformatf("vec%0d_x", i), x0, tbl[i].x);
            chk($sformatf("vec%0d_y", i), y0, tbl[i].y);
            $display("[TB] vec %0d n=%0d ha=%0b hs=%0b eol=%0b x=%0d y=%0d", i, n,
                     h_active0, hsync0, eol0, x0, y0);
        end

        // one complete line, sampled column by column
        while (n < 1600) begin @(posedge clk); n++; end
        c_ha = 0; c_hsl = 0; c_eol = 0; eol_at = -1; hsl_at = -1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (h_active0) c_ha++;
            if (!hsync0) begin c_hsl++; if (hsl_at < 0) hsl_at = i; end
            if (eol0) begin c_eol++; eol_at = i; end
            @(posedge clk); n++;
        end
        chk("line_active_clocks", c_ha, 640);
        chk("line_hsync_low_clocks", c_hsl, 96);
        chk("line_hsync_low_start", hsl_at, 656);
        chk("line_eol_count", c_eol, 1);
        chk("line_eol_column", eol_at, 640);
        $display("[TB] line: active=%0d hsync_low=%0d@%0d eol=%0d@%0d", c_ha, c_hsl, hsl_at, c_eol, eol_at);

        // asynchronous reset in the middle of hsync (column 700)
        while (n < 3100) begin @(posedge clk); n++; end
        #2 rst0 = 1'b1;
        #1;
        chk("async_rst_hsync", hsync0, 1);
        chk("async_rst_h_active", h_active0, 0);
        chk("async_rst_v_active", v_active0, 0);
        chk("async_rst_x", x0, 0);
        chk("async_rst_y", y0, 0);
        @(posedge clk); #1 rst0 = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!eol0 && k < 2000);
        chk("after_rst_eol_seen", eol0, 1);
        k = 0; c_hsl = 0;
        do begin
            @(negedge clk); k++;
            if (!hsync0) c_hsl++;
        end while (!eol0 && k < 2000);
        chk("after_rst_line_period", k, 800);
        chk("after_rst_hsync_low", c_hsl, 96);
        $display("[TB] async reset: line period=%0d hsync_low=%0d", k, c_hsl);

        // full frame on the small instance
        k = 0;
        do begin @(negedge clk); k++; end while (!eof1 && k < 6000);
        chk("frame_eof_seen", eof1, 1);
        @(negedge clk);
        chk("after_eof_x", x1, 0);
        chk("after_eof_y", y1, 0);
        chk("after_eof_h_active", h_active1, 1);
        chk("after_eof_v_active", v_active1, 1);
        k = 1; c_eol = eol1; c_va = v_active1; c_vsl = !vsync1; c_hsh = hsync1; c_ha = eof1;
        do begin
            @(negedge clk); k++;
            if (eol1) c_eol++;
            if (v_active1) c_va++;
            if (!vsync1) c_vsl++;
            if (hsync1) c_hsh++;
        end while (!eof1 && k < 6000);
        chk("frame_period", k, 5200);
        chk("frame_eol_count", c_eol, 13);
        chk("frame_v_active_clocks", c_va, 2400);
        chk("frame_vsync_low_clocks", c_vsl, 800);
        chk("frame_hsync_high_clocks", c_hsh, 13 * 48);
        $display("[TB] frame: period=%0d eol=%0d va=%0d vs_low=%0d hs_high=%0d", k, c_eol, c_va, c_vsl, c_hsh);

        // enable dropped at column 300 of line 5 for five clocks
        k = 0;
        do begin @(negedge clk); k++; end while (!(x1 == 10'd300 && y1 == 10'd5) && k < 6000);
        chk("en_drop_reached", int'(x1 == 10'd300 && y1 == 10'd5), 1);
        en1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("en_off%0d_xy", i), int'(x1) + int'(y1), 0);
            chk($sformatf("en_off%0d_hsync", i), hsync1, 0);
            chk($sformatf("en_off%0d_vsync", i), vsync1, 1);
            chk($sformatf("en_off%0d_pulses", i), int'(eol1) + int'(eof1), 0);
        end
        en1 = 1'b1;
        #1;
        chk("en_first_h_active", h_active1, 1);
        chk("en_first_v_active", v_active1, 1);
        @(negedge clk);
        chk("en_resume_x", x1, 1);
        chk("en_resume_y", y1, 0);
        $display("[TB] enable drop/restart: x=%0d y=%0d", x1, y1);

        // randomized enable drops and asynchronous resets
        off = 0; rhold = 0;
        for (int c = 0; c < 15000; c++) begin
            @(posedge clk); #1;
            if (rhold > 0) begin
                rhold--;
                if (rhold == 0) rst1 = 1'b0;
            end else if ($urandom_range(0, 2999) == 0) begin
                #2 rst1 = 1'b1;
                #1;
                chk("rnd_rst_outputs", {hsync1, vsync1, h_active1, v_active1, eol1, eof1, x1, y1},
                    {1'b0, 1'b1, 4'b0000, 20'd0});
                $display("[TB] random async reset at t=%0t", $time);
                rhold = 1 + $urandom_range(0, 2);
            end
            if (off > 0) begin
                off--;
                if (off == 0) en1 = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                en1 = 1'b0;
                off = $urandom_range(1, 8);
            end
        end
        rst1 = 1'b0; en1 = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACT, 640, active pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch (clocks).
REQ-003 Parameter H_SYNC, 96, horizontal sync width (clocks).
REQ-004 Parameter H_BP, 48, horizontal back porch (clocks).
REQ-005 Parameter V_ACT, 480, active lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, 2, vertical sync width (lines).
REQ-008 Parameter V_BP, 33, vertical back porch (lines).
REQ-009 Parameter HS_POL, 0, hsync asserted level (0 = active-low).
REQ-010 Parameter VS_POL, 0, vsync asserted level (0 = active-low).
REQ-011 Ports, in this order:
- clk_i  in  1  pixel clock.
- rst_i  in  1  reset; asynchronous, active-high.
- en  in  1  timing run enable.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- h_active  out  1  within active columns.
- v_active  out  1  within active lines.
- eol  out  1  end-of-active-line pulse, consumed by the line fetcher.
- eof  out  1  end-of-frame pulse.
- x  out  10  current column count.
- y  out  10  current line count.

Function
REQ-012 H_TOTAL = H_ACT+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525); counters are 10 bits wide; parameter totals exceeding 1024 SHALL be rejected at elaboration.
REQ-013 The horizontal counter h_cnt SHALL advance by 1 per clock while en=1 and SHALL wrap from H_TOTAL-1 to 0.
REQ-014 The vertical counter v_cnt SHALL advance only on the cycle h_cnt=H_TOTAL-1 and SHALL wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-015 Each axis SHALL run a phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
- Transitions SHALL occur at counts ACT, ACT+FP, ACT+FP+SYNC and TOTAL-1 -> 0.
REQ-016 All outputs SHALL be registered, glitch-free, and consistent with the same-cycle value of h_cnt/v_cnt; they SHALL be decoded from next-state values, with no extra latency.
REQ-017 h_active SHALL be 1 when h_cnt<H_ACT.
REQ-018 v_active SHALL be 1 when v_cnt<V_ACT.
REQ-019 hsync SHALL equal HS_POL when H_ACT+H_FP <= h_cnt < H_ACT+H_FP+H_SYNC, and ~HS_POL otherwise; vsync SHALL follow the same rule on v_cnt with VS_POL.
REQ-020 eol SHALL pulse for exactly one clock when h_cnt=H_ACT, on every line including blanking lines, so the downstream fetcher has the full H_FP+H_SYNC+H_BP interval.
REQ-021 eof SHALL pulse for exactly one clock when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
REQ-022 x SHALL equal h_cnt while h_active=1 and 0 otherwise; y SHALL equal v_cnt while v_active=1 and 0 otherwise.
REQ-023 When en=0, both counters SHALL load 0 on the next clock, FSMs SHALL enter ACTIVE, and eol/eof SHALL be 0; hsync/vsync SHALL be deasserted while en=0.
REQ-024 When en rises, counting SHALL resume from h_cnt=0, v_cnt=0, with h_active and v_active asserted on that first enabled cycle.

Reset
REQ-025 While rst_i=1, all of the following SHALL hold, including when reset is asserted mid-frame:
- h_cnt=0 and v_cnt=0;
- both FSMs in ACTIVE;
- hsync=~HS_POL and vsync=~VS_POL;
- h_active=0, v_active=0, eol=0, eof=0, x=0, y=0.
REQ-026 On the first clock after rst_i falls with en=1, the counters SHALL advance normally from 0.

Structure
REQ-027 Shared package vga_pkg SHALL hold the phase enum phase_t {ACTIVE, FRONT, SYNC, BACK} and the default 640x480@60 timing constants.
REQ-028 One sub-module, vga_axis, SHALL hold counter, phase FSM, sync and active decode.
- Parameters: ACT/FP/SYNC/BP/POL.
- Ports: clk_i, rst_i, clr, step, outputs cnt/active/sync/last.
- Instantiated twice; the vertical step is the horizontal last.

Verification
REQ-029 Reset release, en=1 -> 640 clocks h_active=1, eol at h_cnt=640, hsync low clocks 656..751, line period 800.
REQ-030 Full frame -> v_active lines 0..479, vsync low lines 490..491, exactly 525 eol pulses, one eof at (799,524), then (0,0) on the next clock.
REQ-031 Check x/y -> x counts 0..639 then 0; y holds per line, increments after each active line, and is 0 during vertical blanking.
REQ-032 en deasserted at (300,100) for 5 clocks -> counters 0, sync deasserted, no eol/eof; on re-enable, timing restarts at (0,0).
REQ-033 rst_i asserted asynchronously mid-hsync -> outputs reach reset values immediately without waiting for a clock edge; after release, line timing is correct.
REQ-034 Parameter override HS_POL=1, H_ACT=320, H_FP=8, H_SYNC=48, H_BP=24 -> line period 400, hsync high clocks 328..375.
